debug_uart_tx: RTL and testbench

//   Consumer end of the pipeline debug bus. On a start request it snapshots the
//   322-bit debug_signal vector exported by the MIPS_DLX top, which carries all

---
 rtl/debug_uart_tx_pkg.sv | 17 +
 rtl/uart_tx_byte.sv | 85 ++++++++
 rtl/debug_uart_tx.sv | 128 ++++++++++++
 tb/tb_debug_uart_tx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_uart_tx_pkg.sv
// rtl/debug_uart_tx_pkg.sv - shared debug-bus UART constants and frame FSM states
package debug_uart_tx_pkg;

  // Values shared with the pipeline top and the debug RX unit
  localparam int         UART_CLKS_PER_BIT = 434;
  localparam logic [7:0] DEBUG_HEADER      = 8'hA5;
  localparam int         DEBUG_WIDTH       = 322;

  // Frame sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_FIN  = 2'd3
  } dbg_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serializer that can chain bytes with no idle gap
module uart_tx_byte
  import debug_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [3:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;

  // Last cycle of the stop bit; a tx_start seen here begins the next start bit without a gap
  assign tx_done = busy_q && (bit_q == 4'd9) && (baud_q == BAUD_LAST);
  assign tx      = tx_q;
  assign tx_busy = busy_q;

  // Next-state: baud/bit counting, shifting data out LSB first, and (re)start
  always_comb begin
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;

    if (busy_q) begin
      if (baud_q == BAUD_LAST) begin
        baud_d = '0;
        if (bit_q == 4'd9) begin
          busy_d = 1'b0;
          bit_d  = 4'd0;
          tx_d   = 1'b1;
        end else begin
          bit_d = bit_q + 4'd1;
          if (bit_q < 4'd8) begin
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end else begin
            tx_d = 1'b1;
          end
        end
      end else begin
        baud_d = baud_q + BAUD_W'(1);
      end
    end

    if (tx_start && (!busy_q || tx_done)) begin
      shift_d = data;
      tx_d    = 1'b0;
      bit_d   = 4'd0;
      baud_d  = '0;
      busy_d  = 1'b1;
    end
  end

  // Serializer state; the line idles high out of reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      baud_q  <= '0;
      bit_q   <= 4'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: rtl/debug_uart_tx.sv
// rtl/debug_uart_tx.sv - snapshots the pipeline debug vector and streams it as a UART frame
module debug_uart_tx
  import debug_uart_tx_pkg::*;
#(
  parameter int         DEBUG_WIDTH  = debug_uart_tx_pkg::DEBUG_WIDTH,
  parameter int         CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter logic [7:0] HEADER       = DEBUG_HEADER
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [DEBUG_WIDTH-1:0] debug_signal,
  output logic                   tx,
  output logic                   busy,
  output logic                   done
);

  localparam int         NBYTES   = (DEBUG_WIDTH + 7) / 8;
  localparam int         SNAP_W   = 8 * NBYTES;
  localparam logic [5:0] LAST_IDX = 6'(NBYTES);

  dbg_state_e        state_q, state_d;
  logic [SNAP_W-1:0] snap_q, snap_d;
  logic [5:0]        byte_idx_q, byte_idx_d;
  logic [7:0]        next_byte_q, next_byte_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              byte_start;
  logic [7:0]        byte_data;
  logic              byte_busy;
  logic              byte_done;

  // Frame byte k: 0 is the sync header, k>=1 walks the snapshot from its top byte down
  function automatic logic [7:0] byte_select(input logic [SNAP_W-1:0] v, input logic [5:0] idx);
    logic [SNAP_W-1:0] shifted;
    shifted = '0;
    if (idx == 6'd0) return HEADER;
    if (idx > LAST_IDX) return 8'h00;
    shifted = v >> (8 * (NBYTES - int'(idx)));
    return shifted[7:0];
  endfunction

  // Sequencer: header starts straight from IDLE; later bytes are chained on tx_done so
  // there is no gap; LOAD prefetches the following byte while the current one shifts out
  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    byte_idx_d  = byte_idx_q;
    next_byte_d = next_byte_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    byte_start  = 1'b0;
    byte_data   = next_byte_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !byte_busy) begin
          snap_d                  = '0;
          snap_d[DEBUG_WIDTH-1:0] = debug_signal;
          byte_idx_d              = 6'd0;
          busy_d                  = 1'b1;
          byte_start              = 1'b1;
          byte_data               = byte_select(snap_q, 6'd0);
          state_d                 = ST_LOAD;
        end
      end
      ST_LOAD: begin
        next_byte_d = byte_select(snap_q, byte_idx_q + 6'd1);
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        if (byte_done) begin
          if (byte_idx_q < LAST_IDX) begin
            byte_start = 1'b1;
            byte_idx_d = byte_idx_q + 6'd1;
            state_d    = ST_LOAD;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_FIN;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Frame state and registered status outputs; reset aborts any frame in progress
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      snap_q      <= '0;
      byte_idx_q  <= 6'd0;
      next_byte_q <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      byte_idx_q  <= byte_idx_d;
      next_byte_q <= next_byte_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clock   (clock),
    .reset   (reset),
    .tx_start(byte_start),
    .data    (byte_data),
    .tx      (tx),
    .tx_busy (byte_busy),
    .tx_done (byte_done)
  );

endmodule

// File: tb/tb_debug_uart_tx.sv
// tb/tb_debug_uart_tx.sv - scoreboard bench for debug_uart_tx with a line-decoding UART monitor
module tb_debug_uart_tx;

  localparam int BIT   = 4;
  localparam int FRAME = 42 * 10 * BIT;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [321:0] debug_signal;
  logic         tx;
  logic         busy;
  logic         done;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         done_q[$];
  logic [7:0] pay[41];

  int n_cmp  = 0;
  int n_fail = 0;
  int n_done = 0;
  int cyc    = 0;

  debug_uart_tx #(
    .DEBUG_WIDTH (322),
    .CLKS_PER_BIT(BIT),
    .HEADER      (8'hA5)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .debug_signal(debug_signal),
    .tx          (tx),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [321:0] build_vec();
    logic [327:0] t;
    t = '0;
    for (int i = 0; i < 41; i++) t[8*(40-i) +: 8] = pay[i];
    return t[321:0];
  endfunction

  task automatic push_frame(input int s);
    exp_t e;
    e.data = 8'hA5;
    e.cyc  = s;
    exp_q.push_back(e);
    for (int i = 0; i < 41; i++) begin
      e.data = pay[i];
      e.cyc  = s + 10 * BIT * (i + 1);
      exp_q.push_back(e);
    end
    done_q.push_back(s + FRAME);
  endtask

  task automatic wait_negs(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  task automatic wait_done(input int target, input int limit);
    int i;
    i = 0;
    while (n_done < target && i < limit) begin
      @(negedge clock);
      i++;
    end
    check("done_count", n_done, target);
  endtask

  // Single start pulse; the accept edge is the next posedge, so the header starts at cyc+1
  task automatic pulse_frame(input logic [321:0] v);
    debug_signal = v;
    start        = 1'b1;
    push_frame(cyc + 1);
    @(negedge clock);
    start = 1'b0;
  endtask

  // Line monitor: decodes 8N1 bytes, requires each bit to hold for exactly BIT samples
  logic [9:0] mon_bits;
  logic [7:0] mon_data;
  logic       mon_active = 1'b0;
  logic       mon_timing_err;
  int         mon_pos;
  int         mon_start_cyc;

  always @(negedge clock) begin
    if (reset !== 1'b1) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active     = 1'b1;
        mon_bits       = '1;
        mon_bits[0]    = 1'b0;
        mon_pos        = 1;
        mon_start_cyc  = cyc;
        mon_timing_err = 1'b0;
      end
    end else begin
      if (mon_pos % BIT == 0) mon_bits[mon_pos / BIT] = tx;
      else if (tx !== mon_bits[mon_pos / BIT]) mon_timing_err = 1'b1;
      mon_pos++;
      if (mon_pos == 10 * BIT) begin
        mon_active = 1'b0;
        for (int i = 0; i < 8; i++) mon_data[i] = mon_bits[i + 1];
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {24'd0, mon_data}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("byte_data", {24'd0, mon_data}, {24'd0, e.data});
          check("byte_start_cycle", mon_start_cyc, e.cyc);
          check("framing_timing_ok",
                {31'd0, (mon_bits[9] === 1'b1) && !mon_timing_err}, 32'd1);
        end
      end
    end
  end

  // Done monitor: every done pulse must land on its expected cycle with busy already low
  always @(negedge clock) begin
    if (reset === 1'b1 && done === 1'b1) begin
      n_done++;
      if (done_q.size() == 0) begin
        check("unexpected_done", cyc, 32'hFFFF_FFFF);
      end else begin
        check("done_cycle", cyc, done_q.pop_front());
        check("busy_low_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    reset        = 1'b0;
    start        = 1'b0;
    debug_signal = '0;
    wait_negs(3);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    reset = 1'b1;
    wait_negs(2);

    // 1: abort a frame with reset while tx is low, then run a complete frame
    pay[0] = 8'h02;
    for (int k = 1; k < 41; k++) pay[k] = (k % 2 == 1) ? 8'hC3 : 8'h3C;
    pulse_frame(build_vec());
    wait_negs(100);
    i = 0;
    while (tx !== 1'b0 && i < 40) begin
      @(negedge clock);
      i++;
    end
    #1 reset = 1'b0;
    #1;
    check("abort_tx", {31'd0, tx}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    exp_q.delete();
    done_q.delete();
    wait_negs(2);
    reset = 1'b1;
    wait_negs(2);
    pulse_frame(build_vec());
    wait_done(1, FRAME + 100);
    wait_negs(20);

    // 2: vector 1 | 3<<320 gives A5, 03, 00 x39, 01
    for (int k = 0; k < 41; k++) pay[k] = 8'h00;
    pay[0]       = 8'h03;
    pay[40]      = 8'h01;
    debug_signal = 322'h1 | (322'h3 << 320);
    start        = 1'b1;
    push_frame(cyc + 1);
    @(negedge clock);
    start = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    wait_done(2, FRAME + 100);
    wait_negs(20);

    // 3: snapshot is held even though debug_signal goes all-ones right after accept
    for (int k = 0; k < 41; k++) pay[k] = 8'(k + 1);
    debug_signal = build_vec();
    start        = 1'b1;
    push_frame(cyc + 1);
    @(negedge clock);
    start        = 1'b0;
    debug_signal = '1;
    wait_done(3, FRAME + 100);
    wait_negs(20);

    // 4: start pulse during byte 10 is ignored
    pay[0] = 8'h03;
    for (int k = 1; k < 41; k++) pay[k] = 8'hFF;
    pulse_frame('1);
    wait_negs(10 * 10 * BIT + 3);
    debug_signal = '0;
    start        = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(4, FRAME + 100);
    wait_negs(60);

    // 5: start held high: second header begins 2 cycles after the first stop bit ends
    for (int k = 0; k < 41; k++) pay[k] = 8'h00;
    debug_signal = '0;
    start        = 1'b1;
    push_frame(cyc + 1);
    push_frame(cyc + 1 + FRAME + 2);
    wait_negs(FRAME + 100);
    start = 1'b0;
    wait_done(6, FRAME + 100);
    wait_negs(60);

    check("bytes_outstanding", exp_q.size(), 32'd0);
    check("dones_outstanding", done_q.size(), 32'd0);
    check("idle_tx", {31'd0, tx}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
